// File: rtl/sram_arbiter.sv
// Single-port SRAM scheduler: pipeline reads win. Idle slots go to ADC or buffered SPI writes,
// with starvation protection for SPI. Freeze/thaw of the ADC image takes effect at frame start.
module sram_arbiter #(
  parameter int unsigned X_RES            = 800,
  parameter int unsigned Y_RES            = 600,
  parameter int unsigned READ_LATENCY     = 3,
  parameter int unsigned SPI_FIFO_DEPTH   = 8,
  parameter int unsigned SPI_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze_req,
  output logic        frozen,
  input  logic [37:0] adc_pixel_data,
  input  logic        adc_pixel_ready,
  output logic        adc_pixel_read,
  input  logic        spi_pixel_valid,
  input  logic [10:0] spi_pixel_x,
  input  logic [10:0] spi_pixel_y,
  input  logic [15:0] spi_pixel_in,
  output logic        spi_fifo_empty,
  output logic        spi_overflow,
  input  logic        request_active,
  input  logic [10:0] request_x,
  input  logic [10:0] request_y,
  output logic [15:0] request_data,
  output logic        request_ready,
  output logic        sram_we,
  output logic [19:0] sram_addr,
  output logic [17:0] sram_data_in,
  input  logic [17:0] sram_data_out
);

  localparam int unsigned PtrW  = $clog2(SPI_FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned StrkW = $clog2(SPI_STARVE_LIMIT + 1);

  localparam logic [10:0]      XResW   = 11'(X_RES);
  localparam logic [10:0]      YResW   = 11'(Y_RES);
  localparam logic [CntW-1:0]  DepthW  = CntW'(SPI_FIFO_DEPTH);
  localparam logic [StrkW-1:0] LimitW  = StrkW'(SPI_STARVE_LIMIT);

  typedef enum logic [1:0] {StLive, StFreezePend, StFrozen, StThawPend} frz_state_e;

  frz_state_e frz_q, frz_d;

  logic [37:0]       fifo_mem_q [SPI_FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [StrkW-1:0]  streak_q, streak_d;

  logic [READ_LATENCY:0] rd_vld_q, rd_vld_d, rd_oob_q, rd_oob_d;

  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [17:0] wdata_q, wdata_d;

  logic        grant_read, grant_spi, grant_adc;
  logic        spi_pending, fifo_full, push_ok, frame_start, adc_wr_ok;
  logic        rd_inb, spi_inb, adc_inb;
  logic [37:0] head;
  logic [10:0] adc_x, adc_y, head_x, head_y;
  logic        unused_data_hi;

  assign unused_data_hi = ^sram_data_out[17:16];

  assign head   = fifo_mem_q[rd_ptr_q];
  assign head_x = head[37:27];
  assign head_y = head[26:16];
  assign adc_x  = adc_pixel_data[37:27];
  assign adc_y  = adc_pixel_data[26:16];

  assign rd_inb  = (request_x < XResW) && (request_y < YResW);
  assign spi_inb = (head_x < XResW) && (head_y < YResW);
  assign adc_inb = (adc_x < XResW) && (adc_y < YResW);

  assign spi_pending = (count_q != '0);
  assign fifo_full   = (count_q == DepthW);

  assign grant_read = request_active;
  assign grant_spi  = !request_active && spi_pending && (!adc_pixel_ready || streak_q == LimitW);
  assign grant_adc  = !request_active && adc_pixel_ready && !grant_spi;
  assign frame_start = grant_adc && (adc_x == '0) && (adc_y == '0);

  // A full FIFO still takes a push when the head is popped on the same edge.
  assign push_ok = spi_pixel_valid && (!fifo_full || grant_spi);

  always_comb begin
    frz_d     = frz_q;
    adc_wr_ok = 1'b0;
    unique case (frz_q)
      StLive: begin
        adc_wr_ok = 1'b1;
        if (freeze_req) frz_d = StFreezePend;
      end
      StFreezePend: begin
        adc_wr_ok = 1'b1;
        if (!freeze_req) begin
          frz_d = StLive;
        end else if (frame_start) begin
          frz_d     = StFrozen;
          adc_wr_ok = 1'b0;
        end
      end
      StFrozen: begin
        if (!freeze_req) frz_d = StThawPend;
      end
      StThawPend: begin
        if (freeze_req) begin
          frz_d = StFrozen;
        end else if (frame_start) begin
          frz_d     = StLive;
          adc_wr_ok = 1'b1;
        end
      end
      default: frz_d = StLive;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (grant_spi) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok)   wr_ptr_d = wr_ptr_q + PtrW'(1);
    count_d  = count_q + CntW'(push_ok) - CntW'(grant_spi);
    ovf_d    = ovf_q | (spi_pixel_valid && !push_ok);

    streak_d = streak_q;
    if (!spi_pending || grant_spi) begin
      streak_d = '0;
    end else if (grant_adc && streak_q != LimitW) begin
      streak_d = streak_q + StrkW'(1);
    end
  end

  always_comb begin
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_vld_d = {rd_vld_q[READ_LATENCY-1:0], grant_read};
    rd_oob_d = {rd_oob_q[READ_LATENCY-1:0], grant_read && !rd_inb};
    if (grant_read) begin
      if (rd_inb) addr_d = {request_x[9:0], request_y[9:0]};
    end else if (grant_spi) begin
      if (spi_inb) begin
        we_d    = 1'b1;
        addr_d  = {head_x[9:0], head_y[9:0]};
        wdata_d = {2'b00, head[15:0]};
      end
    end else if (grant_adc) begin
      if (adc_inb && adc_wr_ok) begin
        we_d    = 1'b1;
        addr_d  = {adc_x[9:0], adc_y[9:0]};
        wdata_d = {2'b00, adc_pixel_data[15:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz_q    <= StLive;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      streak_q <= '0;
      rd_vld_q <= '0;
      rd_oob_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      frz_q    <= frz_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      streak_q <= streak_d;
      rd_vld_q <= rd_vld_d;
      rd_oob_q <= rd_oob_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= {spi_pixel_x, spi_pixel_y, spi_pixel_in};
  end

  assign adc_pixel_read = grant_adc && !rst;
  assign frozen         = (frz_q == StFrozen) || (frz_q == StThawPend);
  assign spi_fifo_empty = !spi_pending;
  assign spi_overflow   = ovf_q;
  assign request_ready  = rd_vld_q[READ_LATENCY];
  assign request_data   = (rd_vld_q[READ_LATENCY] && !rd_oob_q[READ_LATENCY]) ?
                          sram_data_out[15:0] : 16'h0000;
  assign sram_we        = we_q;
  assign sram_addr      = addr_q;
  assign sram_data_in   = wdata_q;

endmodule
